// File: rtl/pe_seq_pkg.sv
// Shared types and bus widths for the SD4 PE_array sequencer.
package pe_seq_pkg;

  localparam int unsigned LANES  = 4;
  localparam int unsigned IMG_W  = 24;
  localparam int unsigned WGT_W  = 36;
  localparam int unsigned PSUM_W = 16;
  localparam int unsigned EXPB_W = 5;

  localparam int unsigned IMG_BUS_W  = LANES * IMG_W;
  localparam int unsigned WGT_BUS_W  = LANES * WGT_W;
  localparam int unsigned PSUM_BUS_W = LANES * PSUM_W;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_RD    = 3'd1,
    ST_MWAIT = 3'd2,
    ST_PWAIT = 3'd3,
    ST_OUT   = 3'd4
  } state_e;

endpackage

// File: rtl/pe_array_seq.sv
// Sequencer that streams K operand steps into the PE_array, feeding each step's
// outputs back as the next psums, and returns the final psums on a valid/ready port.
module pe_array_seq
  import pe_seq_pkg::*;
#(
  parameter int unsigned AW      = 8,
  parameter int unsigned KW      = 8,
  parameter int unsigned MEM_LAT = 1,
  parameter int unsigned PE_LAT  = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [KW-1:0]         cfg_k,
  input  logic [EXPB_W-1:0]     cfg_exp_bias,
  input  logic [AW-1:0]         cfg_img_base,
  input  logic [AW-1:0]         cfg_wgt_base,
  input  logic [PSUM_BUS_W-1:0] psum_init,
  output logic                  busy,
  output logic                  done,
  output logic                  img_rd_en,
  output logic [AW-1:0]         img_rd_addr,
  input  logic [IMG_BUS_W-1:0]  img_rd_data,
  output logic                  wgt_rd_en,
  output logic [AW-1:0]         wgt_rd_addr,
  input  logic [WGT_BUS_W-1:0]  wgt_rd_data,
  output logic [EXPB_W-1:0]     pe_exp_bias,
  output logic [IMG_BUS_W-1:0]  pe_img,
  output logic [WGT_BUS_W-1:0]  pe_wgt,
  output logic [PSUM_BUS_W-1:0] pe_psum,
  input  logic [PSUM_BUS_W-1:0] pe_out,
  output logic                  res_valid,
  input  logic                  res_ready,
  output logic [PSUM_BUS_W-1:0] res_data
);

  localparam int unsigned LAT_MAX = (MEM_LAT > PE_LAT) ? MEM_LAT : PE_LAT;
  localparam int unsigned CNT_W   = (LAT_MAX > 1) ? $clog2(LAT_MAX) : 1;

  state_e                state_q, state_d;
  logic [KW-1:0]         k_q, k_d;
  logic [KW-1:0]         step_q, step_d;
  logic [AW-1:0]         img_base_q, img_base_d;
  logic [AW-1:0]         wgt_base_q, wgt_base_d;
  logic [CNT_W-1:0]      lat_cnt_q, lat_cnt_d;
  logic [PSUM_BUS_W-1:0] acc_q, acc_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  img_rd_en_q, img_rd_en_d;
  logic                  wgt_rd_en_q, wgt_rd_en_d;
  logic [AW-1:0]         img_rd_addr_q, img_rd_addr_d;
  logic [AW-1:0]         wgt_rd_addr_q, wgt_rd_addr_d;
  logic [EXPB_W-1:0]     pe_exp_bias_q, pe_exp_bias_d;
  logic [IMG_BUS_W-1:0]  pe_img_q, pe_img_d;
  logic [WGT_BUS_W-1:0]  pe_wgt_q, pe_wgt_d;
  logic [PSUM_BUS_W-1:0] pe_psum_q, pe_psum_d;
  logic                  res_valid_q, res_valid_d;
  logic [PSUM_BUS_W-1:0] res_data_q, res_data_d;

  // Next-state and next-output logic
  always_comb begin
    state_d       = state_q;
    k_d           = k_q;
    step_d        = step_q;
    img_base_d    = img_base_q;
    wgt_base_d    = wgt_base_q;
    lat_cnt_d     = lat_cnt_q;
    acc_d         = acc_q;
    done_d        = 1'b0;
    img_rd_en_d   = 1'b0;
    wgt_rd_en_d   = 1'b0;
    img_rd_addr_d = img_rd_addr_q;
    wgt_rd_addr_d = wgt_rd_addr_q;
    pe_exp_bias_d = pe_exp_bias_q;
    pe_img_d      = pe_img_q;
    pe_wgt_d      = pe_wgt_q;
    pe_psum_d     = pe_psum_q;
    res_data_d    = res_data_q;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          k_d           = cfg_k;
          img_base_d    = cfg_img_base;
          wgt_base_d    = cfg_wgt_base;
          pe_exp_bias_d = cfg_exp_bias;
          acc_d         = psum_init;
          step_d        = '0;
          state_d       = (cfg_k != '0) ? ST_RD : ST_OUT;
        end
      end
      ST_RD: begin
        lat_cnt_d = CNT_W'(MEM_LAT - 1);
        state_d   = ST_MWAIT;
      end
      ST_MWAIT: begin
        if (lat_cnt_q == '0) begin
          pe_img_d  = img_rd_data;
          pe_wgt_d  = wgt_rd_data;
          pe_psum_d = acc_q;
          lat_cnt_d = CNT_W'(PE_LAT - 1);
          state_d   = ST_PWAIT;
        end else begin
          lat_cnt_d = lat_cnt_q - CNT_W'(1);
        end
      end
      ST_PWAIT: begin
        if (lat_cnt_q == '0) begin
          acc_d = pe_out;
          if (step_q == k_q - KW'(1)) begin
            state_d = ST_OUT;
          end else begin
            step_d  = step_q + KW'(1);
            state_d = ST_RD;
          end
        end else begin
          lat_cnt_d = lat_cnt_q - CNT_W'(1);
        end
      end
      ST_OUT: begin
        if (res_valid_q && res_ready) begin
          done_d  = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Outputs are registered, so they are derived from the state being entered
    if (state_d == ST_RD) begin
      img_rd_en_d   = 1'b1;
      wgt_rd_en_d   = 1'b1;
      img_rd_addr_d = img_base_d + AW'(step_d);
      wgt_rd_addr_d = wgt_base_d + AW'(step_d);
    end
    busy_d      = (state_d != ST_IDLE);
    res_valid_d = (state_d == ST_OUT);
    if (state_d == ST_OUT) begin
      res_data_d = acc_d;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= ST_IDLE;
      k_q           <= '0;
      step_q        <= '0;
      img_base_q    <= '0;
      wgt_base_q    <= '0;
      lat_cnt_q     <= '0;
      acc_q         <= '0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      img_rd_en_q   <= 1'b0;
      wgt_rd_en_q   <= 1'b0;
      img_rd_addr_q <= '0;
      wgt_rd_addr_q <= '0;
      pe_exp_bias_q <= '0;
      pe_img_q      <= '0;
      pe_wgt_q      <= '0;
      pe_psum_q     <= '0;
      res_valid_q   <= 1'b0;
      res_data_q    <= '0;
    end else begin
      state_q       <= state_d;
      k_q           <= k_d;
      step_q        <= step_d;
      img_base_q    <= img_base_d;
      wgt_base_q    <= wgt_base_d;
      lat_cnt_q     <= lat_cnt_d;
      acc_q         <= acc_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      img_rd_en_q   <= img_rd_en_d;
      wgt_rd_en_q   <= wgt_rd_en_d;
      img_rd_addr_q <= img_rd_addr_d;
      wgt_rd_addr_q <= wgt_rd_addr_d;
      pe_exp_bias_q <= pe_exp_bias_d;
      pe_img_q      <= pe_img_d;
      pe_wgt_q      <= pe_wgt_d;
      pe_psum_q     <= pe_psum_d;
      res_valid_q   <= res_valid_d;
      res_data_q    <= res_data_d;
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign img_rd_en   = img_rd_en_q;
  assign img_rd_addr = img_rd_addr_q;
  assign wgt_rd_en   = wgt_rd_en_q;
  assign wgt_rd_addr = wgt_rd_addr_q;
  assign pe_exp_bias = pe_exp_bias_q;
  assign pe_img      = pe_img_q;
  assign pe_wgt      = pe_wgt_q;
  assign pe_psum     = pe_psum_q;
  assign res_valid   = res_valid_q;
  assign res_data    = res_data_q;

endmodule

// File: tb/tb_pe_array_seq.sv
// Directed bench for pe_array_seq with a 1-cycle buffer model and a psum+1 PE model.
module tb_pe_array_seq;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [7:0]    cfg_k;
  logic [4:0]    cfg_exp_bias;
  logic [7:0]    cfg_img_base;
  logic [7:0]    cfg_wgt_base;
  logic [63:0]   psum_init;
  logic          busy, done;
  logic          img_rd_en, wgt_rd_en;
  logic [7:0]    img_rd_addr, wgt_rd_addr;
  logic [95:0]   img_rd_data = '0;
  logic [143:0]  wgt_rd_data = '0;
  logic [4:0]    pe_exp_bias;
  logic [95:0]   pe_img;
  logic [143:0]  pe_wgt;
  logic [63:0]   pe_psum;
  logic [63:0]   pe_out;
  logic          res_valid;
  logic          res_ready;
  logic [63:0]   res_data;

  int vectors = 0;
  int miscompares = 0;

  pe_array_seq #(.AW(8), .KW(8), .MEM_LAT(1), .PE_LAT(1)) dut (
    .clk(clk), .rst(rst), .start(start), .cfg_k(cfg_k), .cfg_exp_bias(cfg_exp_bias),
    .cfg_img_base(cfg_img_base), .cfg_wgt_base(cfg_wgt_base), .psum_init(psum_init),
    .busy(busy), .done(done),
    .img_rd_en(img_rd_en), .img_rd_addr(img_rd_addr), .img_rd_data(img_rd_data),
    .wgt_rd_en(wgt_rd_en), .wgt_rd_addr(wgt_rd_addr), .wgt_rd_data(wgt_rd_data),
    .pe_exp_bias(pe_exp_bias), .pe_img(pe_img), .pe_wgt(pe_wgt), .pe_psum(pe_psum),
    .pe_out(pe_out), .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data)
  );

  always #5 clk = ~clk;

  function automatic logic [95:0] img_word(input logic [7:0] a);
    return {4{16'hA5C3, a}};
  endfunction

  function automatic logic [143:0] wgt_word(input logic [7:0] a);
    return {4{28'h0B0B0B0, a}};
  endfunction

  function automatic logic [63:0] lanes4(input logic [15:0] v);
    return {4{v}};
  endfunction

  // Operand buffers: read data appears one cycle after the strobe
  always @(posedge clk) begin
    if (img_rd_en) img_rd_data <= img_word(img_rd_addr);
    if (wgt_rd_en) wgt_rd_data <= wgt_word(wgt_rd_addr);
  end

  // PE stand-in: each lane adds one to its psum
  assign pe_out = {pe_psum[63:48] + 16'd1, pe_psum[47:32] + 16'd1,
                   pe_psum[31:16] + 16'd1, pe_psum[15:0] + 16'd1};

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [159:0] obs, input logic [159:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b0; start = 1'b0; cfg_k = '0; cfg_exp_bias = '0;
    cfg_img_base = '0; cfg_wgt_base = '0; psum_init = '0; res_ready = 1'b0;

    // Reset then idle
    tick();
    chk("rst_busy", 160'(busy), 160'(1'b0));
    chk("rst_outs", 160'({res_valid, done, img_rd_en, wgt_rd_en, pe_exp_bias, img_rd_addr, wgt_rd_addr}), 160'(0));
    chk("rst_pe_img", 160'(pe_img), 160'(0));
    chk("rst_pe_wgt", 160'(pe_wgt), 160'(0));
    chk("rst_psum_res", 160'({pe_psum, res_data}), 160'(0));
    rst = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      chk("idle_busy", 160'(busy), 160'(1'b0));
      chk("idle_rden", 160'({img_rd_en, wgt_rd_en}), 160'(2'b00));
      chk("idle_outs", 160'({done, res_valid, pe_exp_bias, pe_psum}), 160'(0));
    end

    // K=3, bases 0x10/0x20, psums start at 3
    cfg_k = 8'd3; cfg_img_base = 8'h10; cfg_wgt_base = 8'h20;
    cfg_exp_bias = 5'h13; psum_init = lanes4(16'd3); res_ready = 1'b1; start = 1'b1;
    tick();
    start = 1'b0;
    for (int s = 0; s < 3; s++) begin
      chk("k3_rd_en", 160'({img_rd_en, wgt_rd_en, busy}), 160'(3'b111));
      chk("k3_img_addr", 160'(img_rd_addr), 160'(8'(8'h10 + s)));
      chk("k3_wgt_addr", 160'(wgt_rd_addr), 160'(8'(8'h20 + s)));
      tick();
      chk("k3_rd_off", 160'({img_rd_en, wgt_rd_en}), 160'(2'b00));
      tick();
      chk("k3_pe_img", 160'(pe_img), 160'(img_word(8'(8'h10 + s))));
      chk("k3_pe_wgt", 160'(pe_wgt), 160'(wgt_word(8'(8'h20 + s))));
      chk("k3_pe_psum", 160'(pe_psum), 160'(lanes4(16'(3 + s))));
      chk("k3_exp_bias", 160'(pe_exp_bias), 160'(5'h13));
      chk("k3_no_valid", 160'(res_valid), 160'(1'b0));
      tick();
    end
    chk("k3_res_valid", 160'(res_valid), 160'(1'b1));
    chk("k3_res_data", 160'(res_data), 160'(lanes4(16'd6)));
    chk("k3_done_early", 160'(done), 160'(1'b0));
    tick();
    chk("k3_done", 160'({done, busy, res_valid}), 160'(3'b100));
    tick();
    chk("k3_done_pulse", 160'(done), 160'(1'b0));

    // K=0: result is psum_init after one cycle, no reads
    cfg_k = 8'd0; psum_init = 64'h0003_0003_0003_0003; start = 1'b1;
    tick();
    start = 1'b0;
    chk("k0_res_valid", 160'({res_valid, busy}), 160'(2'b11));
    chk("k0_res_data", 160'(res_data), 160'(64'h0003_0003_0003_0003));
    chk("k0_no_rd", 160'({img_rd_en, wgt_rd_en}), 160'(2'b00));
    chk("k0_pe_psum", 160'(pe_psum), 160'(lanes4(16'd5)));
    chk("k0_pe_img", 160'(pe_img), 160'(img_word(8'h12)));
    tick();
    chk("k0_done", 160'({done, img_rd_en, wgt_rd_en}), 160'(3'b100));

    // Backpressure with ignored starts
    res_ready = 1'b0; cfg_k = 8'd1; cfg_img_base = 8'h30; cfg_wgt_base = 8'h40;
    psum_init = {16'd4, 16'd3, 16'd2, 16'd1}; start = 1'b1;
    tick();
    start = 1'b0;
    chk("bp_img_addr", 160'(img_rd_addr), 160'(8'h30));
    tick(); tick(); tick();
    chk("bp_res_valid", 160'(res_valid), 160'(1'b1));
    chk("bp_res_data", 160'(res_data), 160'({16'd5, 16'd4, 16'd3, 16'd2}));
    for (int i = 0; i < 5; i++) begin
      start = 1'b1; cfg_k = 8'd5; cfg_exp_bias = 5'h1F;
      tick();
      chk("bp_hold_valid", 160'({res_valid, img_rd_en, done}), 160'(3'b100));
      chk("bp_hold_data", 160'(res_data), 160'({16'd5, 16'd4, 16'd3, 16'd2}));
      chk("bp_exp_bias", 160'(pe_exp_bias), 160'(5'h13));
    end
    start = 1'b0; cfg_exp_bias = 5'h13; res_ready = 1'b1;
    tick();
    chk("bp_done", 160'({done, busy}), 160'(2'b10));

    // Address wrap, then back-to-back start in the done cycle
    cfg_k = 8'd3; cfg_img_base = 8'hFE; cfg_wgt_base = 8'h80; psum_init = '0; start = 1'b1;
    tick();
    start = 1'b0;
    for (int s = 0; s < 3; s++) begin
      chk("wrap_img_addr", 160'(img_rd_addr), 160'(8'(8'hFE + s)));
      chk("wrap_wgt_addr", 160'(wgt_rd_addr), 160'(8'(8'h80 + s)));
      tick(); tick(); tick();
    end
    chk("wrap_res_data", 160'({res_valid, res_data}), 160'({1'b1, lanes4(16'd3)}));
    cfg_k = 8'd1; cfg_img_base = 8'h50; cfg_wgt_base = 8'h51;
    psum_init = lanes4(16'h0100); start = 1'b1;
    tick();
    chk("b2b_done", 160'({done, busy}), 160'(2'b10));
    tick();
    start = 1'b0;
    chk("b2b_rd", 160'({img_rd_en, busy, img_rd_addr, wgt_rd_addr}), 160'({2'b11, 8'h50, 8'h51}));
    tick(); tick(); tick();
    chk("b2b_res", 160'({res_valid, res_data}), 160'({1'b1, lanes4(16'h0101)}));
    tick();
    chk("b2b_done2", 160'(done), 160'(1'b1));

    // Reset during the PWAIT of step 1
    cfg_k = 8'd2; cfg_img_base = 8'h60; cfg_wgt_base = 8'h70;
    psum_init = lanes4(16'h0010); start = 1'b1;
    tick();
    start = 1'b0;
    tick(); tick(); tick(); tick(); tick();
    chk("mid_busy", 160'({busy, pe_psum}), 160'({1'b1, lanes4(16'h0011)}));
    rst = 1'b0;
    #1;
    chk("mid_rst_ctl", 160'({busy, done, res_valid, img_rd_en, wgt_rd_en, img_rd_addr, wgt_rd_addr, pe_exp_bias}), 160'(0));
    chk("mid_rst_pe", 160'({pe_psum, res_data}), 160'(0));
    chk("mid_rst_img", 160'(pe_img), 160'(0));
    tick();
    rst = 1'b1;
    tick();
    chk("mid_no_done", 160'({done, busy, res_valid}), 160'(0));
    tick();
    chk("mid_no_done2", 160'({done, busy, res_valid}), 160'(0));
    cfg_k = 8'd2; psum_init = lanes4(16'h0020); start = 1'b1;
    tick();
    start = 1'b0;
    chk("post_rd", 160'({img_rd_en, img_rd_addr}), 160'({1'b1, 8'h60}));
    for (int i = 0; i < 6; i++) tick();
    chk("post_res", 160'({res_valid, res_data}), 160'({1'b1, lanes4(16'h0022)}));
    tick();
    chk("post_done", 160'({done, busy}), 160'(2'b10));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
